id_ex_register: RTL and testbench

Pipeline register between the ID stage (control decode, register-file read, immediate extraction) and the EX stage of the MIPS core. It captures the four ID control signals, the operand data, the register addresses and the immediate, and presents them to EX one cycle later. It supports hold (stall), bubble insertion (flush) and a global enable used by the debug unit for single-stepping. It also keeps a retired-into-EX instruction counter for the debug unit.

---
 rtl/id_ex_register.sv | 128 ++++++++++++
 tb/tb_id_ex_register.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall hold, flush bubble and debug enable, plus a counter of valid instructions entering EX.
// Latency 1 cycle, all outputs registered; no backpressure of its own, holds whenever enable is low or stall is high.
module id_ex_register #(
    parameter int NB_DATA  = 32,
    parameter int NB_ADDR  = 5,
    parameter int NB_IMM   = 16,
    parameter int NB_FUNCT = 6,
    parameter int NB_COUNT = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic                i_signal_control_mult_A,
    input  logic                i_signal_control_mult_B,
    input  logic                i_signal_control_mult_wb,
    input  logic                i_signal_control_write_data_reg_file,
    input  logic [NB_DATA-1:0]  i_pc,
    input  logic [NB_DATA-1:0]  i_data_rs,
    input  logic [NB_DATA-1:0]  i_data_rt,
    input  logic [NB_ADDR-1:0]  i_rs,
    input  logic [NB_ADDR-1:0]  i_rt,
    input  logic [NB_ADDR-1:0]  i_rd,
    input  logic [NB_IMM-1:0]   i_imm,
    input  logic [NB_FUNCT-1:0] i_funct,
    output logic                o_valid,
    output logic                o_signal_control_mult_A,
    output logic                o_signal_control_mult_B,
    output logic                o_signal_control_mult_wb,
    output logic                o_signal_control_write_data_reg_file,
    output logic [NB_DATA-1:0]  o_pc,
    output logic [NB_DATA-1:0]  o_data_rs,
    output logic [NB_DATA-1:0]  o_data_rt,
    output logic [NB_ADDR-1:0]  o_rs,
    output logic [NB_ADDR-1:0]  o_rt,
    output logic [NB_ADDR-1:0]  o_rd,
    output logic [NB_DATA-1:0]  o_imm_ext,
    output logic [NB_FUNCT-1:0] o_funct,
    output logic [NB_COUNT-1:0] o_instr_count
);

    typedef struct packed {
        logic mult_a;
        logic mult_b;
        logic mult_wb;
        logic write_rf;
    } ctrl_t;

    typedef struct packed {
        logic [NB_DATA-1:0]  pc;
        logic [NB_DATA-1:0]  data_rs;
        logic [NB_DATA-1:0]  data_rt;
        logic [NB_ADDR-1:0]  rs;
        logic [NB_ADDR-1:0]  rt;
        logic [NB_ADDR-1:0]  rd;
        logic [NB_DATA-1:0]  imm_ext;
        logic [NB_FUNCT-1:0] funct;
    } data_t;

    ctrl_t               ctrl_in;
    ctrl_t               ctrl_q;
    data_t               data_in;
    data_t               data_q;
    logic                valid_q;
    logic [NB_COUNT-1:0] count_q;

    // A non-valid slot must never carry live control, so gate at capture.
    always_comb begin
        ctrl_in = '0;
        if (i_valid) begin
            ctrl_in.mult_a   = i_signal_control_mult_A;
            ctrl_in.mult_b   = i_signal_control_mult_B;
            ctrl_in.mult_wb  = i_signal_control_mult_wb;
            ctrl_in.write_rf = i_signal_control_write_data_reg_file;
        end
    end

    always_comb begin
        data_in.pc      = i_pc;
        data_in.data_rs = i_data_rs;
        data_in.data_rt = i_data_rt;
        data_in.rs      = i_rs;
        data_in.rt      = i_rt;
        data_in.rd      = i_rd;
        data_in.imm_ext = {{(NB_DATA-NB_IMM){i_imm[NB_IMM-1]}}, i_imm};
        data_in.funct   = i_funct;
    end

    // Priority: reset > disable > flush > stall > load.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else if (i_enable) begin
            if (i_flush) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end else if (!i_stall) begin
                valid_q <= i_valid;
                ctrl_q  <= ctrl_in;
                data_q  <= data_in;
                if (i_valid) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign o_valid                              = valid_q;
    assign o_signal_control_mult_A              = ctrl_q.mult_a;
    assign o_signal_control_mult_B              = ctrl_q.mult_b;
    assign o_signal_control_mult_wb             = ctrl_q.mult_wb;
    assign o_signal_control_write_data_reg_file = ctrl_q.write_rf;
    assign o_pc                                 = data_q.pc;
    assign o_data_rs                            = data_q.data_rs;
    assign o_data_rt                            = data_q.data_rt;
    assign o_rs                                 = data_q.rs;
    assign o_rt                                 = data_q.rt;
    assign o_rd                                 = data_q.rd;
    assign o_imm_ext                            = data_q.imm_ext;
    assign o_funct                              = data_q.funct;
    assign o_instr_count                        = count_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: expected register snapshots are queued as stimulus is applied and compared after each edge.
module tb_id_ex_register;

    localparam int NB_COUNT = 4;

    logic        i_clock = 1'b0;
    logic        i_reset, i_enable, i_stall, i_flush, i_valid;
    logic [3:0]  ctrl;
    logic [31:0] i_pc, i_data_rs, i_data_rt;
    logic [4:0]  i_rs, i_rt, i_rd;
    logic [15:0] i_imm;
    logic [5:0]  i_funct;

    logic        o_valid, o_a, o_b, o_wb, o_wr;
    logic [31:0] o_pc, o_data_rs, o_data_rt, o_imm_ext;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic [5:0]  o_funct;
    logic [NB_COUNT-1:0] o_instr_count;

    typedef struct packed {
        logic                valid;
        logic [3:0]          ctrl;
        logic [31:0]         pc;
        logic [31:0]         drs;
        logic [31:0]         drt;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          rd;
        logic [31:0]         imm_ext;
        logic [5:0]          funct;
        logic [NB_COUNT-1:0] count;
    } snap_t;

    snap_t m;
    snap_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    step_no  = 0;

    id_ex_register #(.NB_COUNT(NB_COUNT)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
        .i_signal_control_mult_A(ctrl[3]), .i_signal_control_mult_B(ctrl[2]),
        .i_signal_control_mult_wb(ctrl[1]), .i_signal_control_write_data_reg_file(ctrl[0]),
        .i_pc(i_pc), .i_data_rs(i_data_rs), .i_data_rt(i_data_rt),
        .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_imm(i_imm), .i_funct(i_funct),
        .o_valid(o_valid),
        .o_signal_control_mult_A(o_a), .o_signal_control_mult_B(o_b),
        .o_signal_control_mult_wb(o_wb), .o_signal_control_write_data_reg_file(o_wr),
        .o_pc(o_pc), .o_data_rs(o_data_rs), .o_data_rt(o_data_rt),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_imm_ext(o_imm_ext),
        .o_funct(o_funct), .o_instr_count(o_instr_count)
    );

    always #5 i_clock = ~i_clock;

    function automatic snap_t observed();
        snap_t s;
        s.valid   = o_valid;
        s.ctrl    = {o_a, o_b, o_wb, o_wr};
        s.pc      = o_pc;
        s.drs     = o_data_rs;
        s.drt     = o_data_rt;
        s.rs      = o_rs;
        s.rt      = o_rt;
        s.rd      = o_rd;
        s.imm_ext = o_imm_ext;
        s.funct   = o_funct;
        s.count   = o_instr_count;
        return s;
    endfunction

    // Advance the reference state from the inputs presented before this edge.
    task automatic tick();
        snap_t exp_s, obs_s;
        if (!i_reset) begin
            m = '0;
        end else if (i_enable) begin
            if (i_flush) begin
                m.valid = 1'b0;
                m.ctrl  = 4'b0000;
            end else if (!i_stall) begin
                m.valid   = i_valid;
                m.ctrl    = i_valid ? ctrl : 4'b0000;
                m.pc      = i_pc;
                m.drs     = i_data_rs;
                m.drt     = i_data_rt;
                m.rs      = i_rs;
                m.rt      = i_rt;
                m.rd      = i_rd;
                m.imm_ext = 32'($signed(i_imm));
                m.funct   = i_funct;
                if (i_valid) m.count = m.count + 1'b1;
            end
        end
        sb_q.push_back(m);
        @(posedge i_clock);
        #1;
        step_no++;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty step=%0d", step_no);
        end else begin
            exp_s = sb_q.pop_front();
            obs_s = observed();
            assert (obs_s === exp_s) else begin
                n_errors++;
                $error("FAIL step%0d observed=%h expected=%h", step_no, obs_s, exp_s);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_instr(input logic v, input logic [3:0] c, input logic [31:0] base);
        i_valid   = v;
        ctrl      = c;
        i_pc      = base + 32'd4;
        i_data_rs = base ^ 32'hA5A5_0001;
        i_data_rt = base ^ 32'h5A5A_0002;
        i_rs      = base[4:0];
        i_rt      = base[9:5];
        i_rd      = base[14:10];
        i_imm     = base[31:16] ^ base[15:0];
        i_funct   = base[5:0] ^ 6'h2A;
    endtask

    initial begin
        m = '0;
        // Reset with every input non-zero.
        i_reset = 1'b0; i_enable = 1'b1; i_stall = 1'b1; i_flush = 1'b1;
        set_instr(1'b1, 4'hF, 32'hDEAD_BEEF);
        tick(); tick();
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_count", 32'(o_instr_count), 32'd0);
        chk("reset_pc", o_pc, 32'd0);

        // Load and sign-extend.
        i_reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        set_instr(1'b1, 4'hF, 32'h0000_1000);
        i_imm = 16'h8001; i_data_rs = 32'h1234_5678;
        tick();
        chk("ext_neg", o_imm_ext, 32'hFFFF_8001);
        chk("load_drs", o_data_rs, 32'h1234_5678);
        chk("load_ctrl", 32'({o_a, o_b, o_wb, o_wr}), 32'hF);
        chk("load_count", 32'(o_instr_count), 32'd1);
        i_imm = 16'h7FFF;
        tick();
        chk("ext_pos", o_imm_ext, 32'h0000_7FFF);

        // Stall holds instruction A over changing inputs.
        set_instr(1'b1, 4'b1010, 32'h0000_A000);
        tick();
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_instr(1'b1, 4'(k + 5), 32'h1111_0000 + 32'(k * 7919));
            tick();
        end
        chk("stall_hold_pc", o_pc, 32'h0000_A004);
        i_stall = 1'b0;
        set_instr(1'b1, 4'b0101, 32'h0000_B000);
        tick();
        chk("stall_release_count", 32'(o_instr_count), 32'd4);

        // Flush wins over stall with a valid R-type at the input.
        i_flush = 1'b1; i_stall = 1'b1;
        set_instr(1'b1, 4'b1101, 32'h0000_C021);
        tick();
        chk("flush_ctrl", 32'({o_valid, o_a, o_b, o_wb, o_wr}), 32'd0);
        chk("flush_data_hold", o_pc, 32'h0000_B004);
        i_stall = 1'b0;

        // Disable overrides flush; then single-cycle enable pulses.
        tick();
        set_instr(1'b1, 4'hF, 32'h0000_D000);
        i_flush = 1'b0; tick();
        i_enable = 1'b0; i_flush = 1'b1; tick(); tick();
        chk("disable_hold_pc", o_pc, 32'h0000_D004);
        i_flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_instr(1'b1, 4'b0011, 32'h0000_E000 + 32'(k * 16));
            i_enable = 1'b1; tick();
            i_enable = 1'b0;
            set_instr(1'b1, 4'b1100, 32'h0000_F000 + 32'(k * 16));
            tick();
        end
        chk("pulse_count", 32'(o_instr_count), 32'd8);
        i_enable = 1'b1;

        // Counter wrap: 17 valid loads interleaved with bubbles after a reset.
        i_reset = 1'b0; tick(); i_reset = 1'b1;
        for (int k = 0; k < 17; k++) begin
            set_instr(1'b1, 4'b1001, 32'h2000_0000 + 32'(k * 101));
            tick();
            set_instr(1'b0, 4'hF, 32'h3000_0000 + 32'(k * 37));
            tick();
            chk("bubble_ctrl", 32'({o_valid, o_a, o_b, o_wb, o_wr}), 32'd0);
        end
        chk("wrap_count", 32'(o_instr_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
